// File: rtl/chunk_serializer.sv
// chunk_serializer: loads one word and emits it MSB-first as CHUNK-bit
// chunks, zero-padded at the top so the bit count is a multiple of CHUNK.
module chunk_serializer #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [WIDTH-1:0] ld_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [CHUNK-1:0] out_chunk,
  output logic [3:0]       out_idx,
  output logic             out_last,
  output logic             done
);

  localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
  localparam int SW     = NCHUNK * CHUNK;
  localparam logic [3:0] LAST = 4'(NCHUNK - 1);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t          r_state;
  state_t          w_state_nx;
  logic [SW-1:0]   r_shadow;
  logic [3:0]      r_idx;
  logic            r_done;
  logic            w_load;
  logic            w_xfer;
  logic            w_at_last;

  assign w_at_last = (r_idx == LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nx;
  end

  // Next state plus load/transfer strobes.
  always_comb begin
    w_state_nx = r_state;
    w_load     = 1'b0;
    w_xfer     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (ld_valid) begin
          w_load     = 1'b1;
          w_state_nx = SEND;
        end
      end
      SEND: begin
        w_xfer = out_ready;
        if (out_ready && w_at_last)
          w_state_nx = IDLE;
      end
      default: w_state_nx = IDLE;
    endcase
  end

  // Shadow shift register, chunk index and end-of-word pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shadow <= '0;
      r_idx    <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_xfer && w_at_last;
      if (w_load) begin
        r_shadow <= SW'(ld_data);
        r_idx    <= '0;
      end else if (w_xfer) begin
        r_shadow <= r_shadow << CHUNK;
        r_idx    <= r_idx + 4'd1;
      end
    end
  end

  assign ld_ready  = (r_state == IDLE);
  assign out_valid = (r_state == SEND);
  assign out_chunk = out_valid ? r_shadow[SW-1 -: CHUNK] : '0;
  assign out_idx   = out_valid ? r_idx : 4'd0;
  assign out_last  = out_valid && w_at_last;
  assign done      = r_done;

endmodule

// File: doc/chunk_serializer.md
# chunk_serializer

Upstream feeder for the 64-bit chunked shift register: accepts one full-width word over a valid/ready load port and emits it MSB-first as 5-bit chunks, one per accepted transfer. Zero padding is prepended so that the total bit count is a multiple of CHUNK. After the final chunk has been shifted in, the downstream register holds the word exactly, with the pad bits shifted out the top. `out_valid && out_ready` is the downstream shift enable. The downstream stage must shift only on that condition.

## Interface
- WIDTH, 64: word width in bits.
- CHUNK, 5: chunk width in bits; must equal the downstream input width.
- NCHUNK, derived = ceil(WIDTH/CHUNK) = 13: chunks per word.
- PAD, derived = NCHUNK*CHUNK − WIDTH = 1: zero bits prepended at the MSB end of chunk 0.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- ld_valid  in  1  load request.
- ld_ready  out  1  block can accept a word.
- ld_data  in  WIDTH  word to serialize.
- out_ready  in  1  downstream accepts the current chunk.
- out_valid  out  1  out_chunk is valid.
- out_chunk  out  CHUNK  current chunk; bit CHUNK−1 is the earliest bit in time.
- out_idx  out  4  index of the current chunk, 0..NCHUNK−1.
- out_last  out  1  current chunk is chunk NCHUNK−1.
- done  out  1  one-cycle pulse after the last chunk is accepted.

## Operation
- Two states, IDLE and SEND. Reset puts the block in IDLE and clears the shadow register, the index and done.
- ld_ready = (state == IDLE). Load fires when ld_valid && ld_ready.
- On load: shadow (NCHUNK*CHUNK bits) ← {PAD'b0, ld_data}; idx ← 0; state → SEND.
- In SEND, out_valid = 1 and out_chunk = shadow[top CHUNK bits]. Chunk 0 is therefore {1'b0, ld_data[63:60]}, and chunk k ≥ 1 is ld_data[64−5k : 60−5k].
- On transfer (out_valid && out_ready):
  - shadow shifts left by CHUNK, zero-filled;
  - idx increments;
  - if out_last was set, state → IDLE and done is set for the next cycle.
- Backpressure: while out_ready = 0, out_chunk, out_idx and out_last hold steady. No bit is lost or duplicated.
- ld_valid while in SEND is ignored; the in-flight word and ld_data are not captured.
- In IDLE: out_valid = 0, out_chunk = 0, out_idx = 0, out_last = 0.
- out_last = (state == SEND) && (idx == NCHUNK−1).
- done is high only in the cycle immediately after the final transfer, never otherwise.
- Reset during SEND returns the block to IDLE next cycle. The partial word is discarded and done is not pulsed.
- Reset dominates a simultaneous load or transfer.

## Timing
- Reset values: ld_ready = 1, out_valid = 0, out_chunk = 0, out_idx = 0, out_last = 0, done = 0.
- Load accepted at edge N: out_valid = 1 with chunk 0 from cycle N+1. Latency is 1 cycle.
- With out_ready held at 1:
  - chunks appear in cycles N+1..N+13;
  - out_last is high in cycle N+13;
  - done and ld_ready are high in cycle N+14.
- Minimum word period is NCHUNK+1 = 14 cycles.
- Every output is a register or a decode of the state and index only. There is no combinational path from any input to any output.

## Test plan
- Reset, then idle for 5 cycles → ld_ready = 1, out_valid = 0, out_chunk = 0, done = 0 throughout.
- Load 0xFFFFFFFFFFFFFFFF with out_ready = 1 → chunk 0 = 0x0F, chunks 1..12 = 0x1F, out_last only on idx 12, done one cycle later.
- Load 0x8000000000000001 → chunk 0 = 0x08, chunks 1..11 = 0x00, chunk 12 = 0x01. Then, with the serializer connected to the downstream shift register, the register's 4-bit output = 0x8 after the last transfer.
- Backpressure: pull out_ready low for 3 cycles at idx 4 → chunk and idx held; the 13 accepted chunks remain correct; total word period = 17 cycles.
- ld_valid with a different word asserted during SEND → ignored; after done, a new load of 0x0123456789ABCDEF gives chunk 0 = 0x00, chunk 1 = 0x02.
- Reset asserted at idx 6 → next cycle in IDLE with outputs at reset values, no done pulse; a subsequent load serializes cleanly from chunk 0.
